// File: rtl/npu_pkg.sv
// Shared types and limits for the NPU streaming blocks.
package npu_pkg;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_PACK,
    PK_DRAIN,
    PK_DONE
  } packer_state_t;

  localparam int PACKER_MAX_LANES = 64;

endpackage

// File: rtl/npu_stream_packer.sv
// Packs LANES serial elements into one zero-padded word with strobe and last flag.
// Optional backpressure stall counter: define NPU_PACKER_STALL_CNT_EN.
module npu_stream_packer
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        total_elems,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_strb,
  output logic                        out_last,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);

  localparam int LANE_W = $clog2(LANES);
  localparam int WORD_W = DATA_WIDTH * LANES;

  if (LANES < 2 || LANES > PACKER_MAX_LANES || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
    $error("LANES must be a power of two between 2 and PACKER_MAX_LANES");
  end

  packer_state_t         state, state_next;
  logic [CNT_WIDTH-1:0]  total_q, total_m1, elem_cnt;
  logic [LANE_W-1:0]     lane_idx;
  logic [WORD_W-1:0]     acc, word_next;
  logic [LANES-1:0]      strb_next;
  logic                  start_acc, completing, is_last, in_hs, out_hs;

  assign start_acc  = (state == PK_IDLE) && start;
  assign total_m1   = total_q - CNT_WIDTH'(1);
  assign is_last    = (elem_cnt == total_m1);
  // lane_idx is all-ones exactly on the top lane because LANES is a power of two.
  assign completing = (&lane_idx) || is_last;

  assign busy     = (state != PK_IDLE);
  assign done     = (state == PK_DONE);
  assign in_ready = (state == PK_PACK) && (!completing || !out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // The accumulator only holds lanes below lane_idx, so the lanes above are already zero.
  always_comb begin
    word_next = acc;
    strb_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k[LANE_W-1:0] == lane_idx) word_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      strb_next[k] = (k[LANE_W-1:0] <= lane_idx);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      PK_IDLE:  if (start) state_next = (total_elems == '0) ? PK_DONE : PK_PACK;
      PK_PACK:  if (in_hs && is_last) state_next = PK_DRAIN;
      PK_DRAIN: if (out_hs && out_last) state_next = PK_DONE;
      PK_DONE:  state_next = PK_IDLE;
      default:  state_next = PK_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PK_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      elem_cnt  <= '0;
      lane_idx  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (start_acc) begin
        total_q  <= total_elems;
        elem_cnt <= '0;
        lane_idx <= '0;
        acc      <= '0;
      end else if (in_hs) begin
        lane_idx <= lane_idx + LANE_W'(1);
        if (!is_last) elem_cnt <= elem_cnt + CNT_WIDTH'(1);
        acc <= completing ? '0 : word_next;
      end
      // A drain and a reload in the same cycle leave out_valid high: no bubble.
      if (out_hs) out_valid <= 1'b0;
      if (in_hs && completing) begin
        out_valid <= 1'b1;
        out_data  <= word_next;
        out_strb  <= strb_next;
        out_last  <= is_last;
      end
    end
  end

`ifdef NPU_PACKER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (busy && out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_npu_stream_packer.sv
// Self-checking bench for npu_stream_packer: queue-based word model plus literal checks.
module tb_npu_stream_packer;

  localparam int DW = 8;
  localparam int L  = 8;
  localparam int CW = 32;

  logic          clk, rst_n, start, busy, done;
  logic [CW-1:0] total_elems, stall_cnt;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data;
  logic [63:0]   out_data;
  logic [7:0]    out_strb;

  npu_stream_packer #(.DATA_WIDTH(DW), .LANES(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_elems(total_elems),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } exp_word_t;

  exp_word_t   exp_q[$];
  logic [7:0]  vals[0:63];
  logic [63:0] got_data[0:7];
  logic [7:0]  got_strb[0:7];
  logic        got_last[0:7];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, last_hs_cyc = 0, words_seen = 0;
  int drv_idx = 0, ready_low_cnt = 0, ready_low_other = 0;
  bit any_valid = 0, abort = 0, prev_stalled = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_strb;
  logic        prev_last;

  `ifdef NPU_PACKER_STALL_CNT_EN
  localparam logic [63:0] EXP_BP_STALL = 64'd10;
  `else
  localparam logic [63:0] EXP_BP_STALL = 64'd0;
  `endif

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Word model: element i lands in word i/L, lane i%L; final word is padded and flagged last.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int w = 0; w * L < n; w++) begin
      exp_word_t e;
      e.data = '0;
      e.strb = '0;
      for (int k = 0; k < L; k++) begin
        if (w * L + k < n) begin
          e.data[k*DW +: DW] = vals[w*L+k];
          e.strb[k] = 1'b1;
        end
      end
      e.last = ((w + 1) * L >= n);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_word_t e;
    if (prev_stalled) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, prev_data);
      check("hold_strb", 64'(out_strb), 64'(prev_strb));
      check("hold_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && out_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word_data", out_data, e.data);
        check("word_strb", 64'(out_strb), 64'(e.strb));
        check("word_last", 64'(out_last), 64'(e.last));
      end
      if (words_seen < 8) begin
        got_data[words_seen] = out_data;
        got_strb[words_seen] = out_strb;
        got_last[words_seen] = out_last;
      end
      words_seen++;
      if (out_last) last_hs_cyc = cyc;
    end
    if (out_valid) any_valid = 1;
    prev_stalled = out_valid && !out_ready && rst_n;
    prev_data = out_data;
    prev_strb = out_strb;
    prev_last = out_last;
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    total_elems = CW'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input int n);
    int guard = 0;
    drv_idx = 0;
    if (n == 0) return;
    in_valid = 1'b1;
    in_data = vals[0];
    while (drv_idx < n && !abort && guard < 500) begin
      logic hs;
      @(negedge clk);
      hs = in_valid && in_ready;
      if (in_valid && !in_ready) begin
        ready_low_cnt++;
        if (drv_idx != n - 1) ready_low_other++;
      end
      @(posedge clk); #1;
      if (hs) begin
        drv_idx++;
        if (drv_idx < n) in_data = vals[drv_idx];
      end
      guard++;
    end
    in_valid = 1'b0;
    if (!abort) check("elements_sent", 64'(drv_idx), 64'(n));
  endtask

  task automatic wait_done(output int dcyc);
    int seen = 0;
    dcyc = -1;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        dcyc = cyc;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic new_test(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) vals[i] = base + 8'(i);
    build_expected(n);
    words_seen = 0;
    ready_low_cnt = 0;
    ready_low_other = 0;
    any_valid = 0;
  endtask

  initial begin
    int dcyc;
    int dpulses;
    rst_n = 0; start = 0; total_elems = '0; in_valid = 0; in_data = '0; out_ready = 1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    #22 rst_n = 1;

    // Two full words at full rate.
    new_test(16, 8'h00);
    do_start(16);
    check("t1_busy_t1", 64'(busy), 64'd1);
    check("t1_in_ready_t1", 64'(in_ready), 64'd1);
    send_stream(16);
    wait_done(dcyc);
    check("t1_word0", got_data[0], 64'h0706050403020100);
    check("t1_word1", got_data[1], 64'h0F0E0D0C0B0A0908);
    check("t1_strb0", 64'(got_strb[0]), 64'hFF);
    check("t1_strb1", 64'(got_strb[1]), 64'hFF);
    check("t1_last0", 64'(got_last[0]), 64'd0);
    check("t1_last1", 64'(got_last[1]), 64'd1);
    check("t1_words", 64'(words_seen), 64'd2);
    check("t1_ready_low", 64'(ready_low_cnt), 64'd0);
    check("t1_done_lat", 64'(dcyc), 64'(last_hs_cyc + 1));
    check("t1_total_cycles", 64'(dcyc - start_cyc + 1), 64'd19);
    @(negedge clk);
    check("t1_busy_f2", 64'(busy), 64'd0);
    check("t1_done_f2", 64'(done), 64'd0);
    check("t1_stall", 64'(stall_cnt), 64'd0);

    // Partial final word.
    new_test(11, 8'h00);
    do_start(11);
    send_stream(11);
    wait_done(dcyc);
    check("t2_word1", got_data[1], 64'h00000000000A0908);
    check("t2_strb1", 64'(got_strb[1]), 64'h07);
    check("t2_last1", 64'(got_last[1]), 64'd1);
    check("t2_words", 64'(words_seen), 64'd2);

    // Backpressure: out_ready low for 10 cycles once word0 is valid.
    new_test(16, 8'h00);
    do_start(16);
    fork
      send_stream(16);
      begin
        int waited = 0;
        while (!out_valid && waited < 100) begin
          @(posedge clk); #1;
          waited++;
        end
        check("t3_word0_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done(dcyc);
    check("t3_word0", got_data[0], 64'h0706050403020100);
    check("t3_word1", got_data[1], 64'h0F0E0D0C0B0A0908);
    check("t3_ready_low", 64'(ready_low_cnt), 64'd3);
    check("t3_ready_low_other", 64'(ready_low_other), 64'd0);
    check("t3_stall", 64'(stall_cnt), EXP_BP_STALL);
    @(negedge clk);
    check("t3_stall_hold", 64'(stall_cnt), EXP_BP_STALL);

    // Zero-length transfer.
    new_test(0, 8'h00);
    do_start(0);
    check("t4_done_t1", 64'(done), 64'd1);
    wait_done(dcyc);
    check("t4_done_lat", 64'(dcyc), 64'(start_cyc + 1));
    @(negedge clk);
    check("t4_busy_t2", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("t4_no_valid", 64'(any_valid), 64'd0);
    check("t4_stall_clr", 64'(stall_cnt), 64'd0);

    // Second start mid-transfer is ignored.
    new_test(16, 8'h30);
    do_start(16);
    fork
      send_stream(16);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1; total_elems = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    wait_done(dcyc);
    check("t5_word0", got_data[0], 64'h3736353433323130);
    check("t5_word1", got_data[1], 64'h3F3E3D3C3B3A3938);
    check("t5_words", 64'(words_seen), 64'd2);

    // Reset after the 5th element aborts the transfer.
    new_test(16, 8'h50);
    do_start(16);
    fork
      send_stream(16);
      begin
        int waited = 0;
        while (drv_idx < 5 && waited < 100) begin
          @(posedge clk); #2;
          waited++;
        end
        check("t6_five_elems", 64'(drv_idx), 64'd5);
        rst_n = 1'b0;
        abort = 1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_data", out_data, 64'd0);
        check("t6_out_strb", 64'(out_strb), 64'd0);
        check("t6_out_last", 64'(out_last), 64'd0);
        check("t6_stall", 64'(stall_cnt), 64'd0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    abort = 0;
    exp_q.delete();
    dpulses = 0;
    repeat (4) begin
      @(negedge clk);
      dpulses += int'(done);
    end
    check("t6_no_done", 64'(dpulses), 64'd0);
    check("t6_no_word", 64'(words_seen), 64'd0);

    // Clean transfer after the aborted one.
    new_test(8, 8'h80);
    do_start(8);
    send_stream(8);
    wait_done(dcyc);
    check("t7_word0", got_data[0], 64'h8786858483828180);
    check("t7_strb0", 64'(got_strb[0]), 64'hFF);
    check("t7_last0", 64'(got_last[0]), 64'd1);
    check("t7_words", 64'(words_seen), 64'd1);
    check("t7_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_stream_packer.md
# npu_stream_packer

Element-to-word packer that sits directly downstream of the tensor reshape stage. It consumes a serial stream of DATA_WIDTH-bit tensor elements and packs LANES consecutive elements into one wide word for the activation SRAM write port. A transfer carries a programmed element count. The final, possibly partial, word is zero-padded and tagged with a lane strobe and a last flag.

## Interface
- DATA_WIDTH, 8, bits per element
- LANES, 8, elements per output word (power of two, ≥2)
- CNT_WIDTH, 32, width of element and stall counters
- clk  in  1  clock
- rst_n  in  1  reset; rst_n, asynchronous, active-low; clock clk
- start  in  1  one-cycle start pulse; sampled only in IDLE
- total_elems  in  CNT_WIDTH  elements in this transfer; latched on accepted start
- busy  out  1  high from the cycle after accepted start until the done cycle
- done  out  1  one-cycle completion pulse
- in_valid / in_ready  in / out  1  element handshake
- in_data  in  DATA_WIDTH  element
- out_valid / out_ready  out / in  1  word handshake
- out_data  out  DATA_WIDTH*LANES  packed word; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_strb  out  LANES  lane-valid mask
- out_last  out  1  marks the final word of the transfer
- stall_cnt  out  CNT_WIDTH  output-backpressure cycles in the current transfer

## Operation
- The FSM has four states: IDLE, PACK, DRAIN and DONE.
- IDLE:
  - On start, latch total_elems, clear elem_cnt, lane_idx and stall_cnt, and set busy.
  - Go to PACK, or to DONE if total_elems==0.
- PACK:
  - An element handshake writes in_data into accumulator lane lane_idx, then increments lane_idx (mod LANES) and elem_cnt.
  - completing = (lane_idx==LANES-1) || (elem_cnt==total-1).
  - On a completing handshake, {acc, in_data} loads the output register in the same cycle.
    - Unfilled lanes are zero; out_strb = (1<<(lane_idx+1))-1; out_last = (elem_cnt==total-1).
    - The accumulator clears.
  - If the completing element was the last one, go to DRAIN.
- in_ready = (state==PACK) && (!completing || !out_valid || out_ready). A non-completing element is always accepted in PACK.
- The output register is one deep and holds its value while out_valid && !out_ready. out_data, out_strb and out_last are stable under backpressure.
- DRAIN: when the out_last word handshakes, go to DONE.
- DONE: pulse done, clear busy, go to IDLE.
- start outside IDLE is ignored. Input that arrives in IDLE, DRAIN or DONE is not accepted.
- Counters wrap nowhere: elem_cnt never exceeds total-1, and lane_idx wraps modulo LANES.
- The same cycle can free the output register (handshake) and reload it (completing element). Both happen, and the word stream has no bubble.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_strb=0, out_last=0, stall_cnt=0, state=IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. The pending word is discarded and no done pulse is issued.
- Start accepted at cycle T: busy=1 and in_ready=1 at T+1.
- Latency: out_valid rises the cycle after the completing element handshake.
- Throughput: 1 element/cycle sustained while out_ready=1, giving one word every LANES cycles.
- Final word handshake at cycle F: done=1 at F+1 (DONE state), busy=0 and state=IDLE at F+2.
- total_elems==0: start at T, done=1 at T+1, and no out_valid at any point.
- Total cycles for n full-rate elements: n + 3 from start to done.

## Configuration
- NPU_PACKER_STALL_CNT_EN:
  - Defined: stall_cnt increments every cycle with busy && out_valid && !out_ready. It saturates at all-ones, clears on accepted start, and holds after done.
  - Undefined: stall_cnt is tied to 0 and no counter flops are built.

## Structure
- npu_pkg gains:
  - packer_state_t, a 2-bit enum {PK_IDLE, PK_PACK, PK_DRAIN, PK_DONE};
  - the constant PACKER_MAX_LANES = 64, checked against LANES by a static assertion.
- No sub-module. The accumulator, output register and FSM live in one module; the output register is not a generic skid buffer because its load is fused with the accumulator.

## Test plan
- Full words: LANES=8, total=16, bytes 0x00..0x0F, out_ready=1.
  - Expect word0 0x0706050403020100 and word1 0x0F0E0D0C0B0A0908, both with strb 0xFF.
  - Expect last only on word1, done 1 cycle after the word1 handshake, and in_ready never low during PACK.
- Partial final word: total=11, bytes 0x00..0x0A.
  - Expect word1 = 0x00000000000A0908, strb=0x07, last=1.
- Backpressure: total=16, out_ready=0 for 10 cycles starting when word0 becomes valid.
  - Expect in_ready to drop on the 16th element only.
  - Expect word0 to be held stable throughout.
  - With the macro, expect stall_cnt=10; without it, stall_cnt=0.
- Zero length: total=0. Expect done at T+1, busy low again at T+2, and no out_valid.
- Misuse and reset:
  - A second start mid-transfer is ignored, and the output is unchanged for total=16.
  - rst_n asserted after the 5th element forces all outputs to reset values.
  - A subsequent start with total=8 produces one correct word.
